// File: rtl/irq_priority_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_priority_ctrl_pkg
// Shared definitions for the interrupt priority controller: the FSM state
// encoding and the default request-line count / encoded index width.
// -----------------------------------------------------------------------------
package irq_priority_ctrl_pkg;

   localparam int unsigned IRQ_N_DEF     = 4;
   localparam int unsigned IRQ_IDX_W_DEF = 2;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } irq_state_t;

endpackage

// File: rtl/irq_priority_ctrl_prio_enc4.sv
// -----------------------------------------------------------------------------
// prio_enc4
// Combinational 4-line priority encoder; the highest-numbered set bit wins.
// Ports:
//   y   [3:0] in  : candidate lines
//   a   [1:0] out : index of the highest set bit (0 when none set)
//   any       out : OR of y
// -----------------------------------------------------------------------------
module prio_enc4 (
   input  logic [3:0] y,
   output logic [1:0] a,
   output logic       any
);

   always_comb begin
      a = '0;
      if (y[3])      a = 2'd3;
      else if (y[2]) a = 2'd2;
      else if (y[1]) a = 2'd1;
      else           a = 2'd0;
   end

   assign any = |y;

endmodule

// File: rtl/irq_priority_ctrl.sv
// -----------------------------------------------------------------------------
// irq_priority_ctrl
// Captures rising edges on asynchronous request lines into sticky pending
// bits, selects the highest-numbered unmasked pending line and presents its
// index through a valid/ready handshake. Re-arrival of an edge on a line that
// is still pending is flagged in a sticky overrun bit.
// Ports:
//   clk        in        : system clock, rising edge
//   rst_n      in        : asynchronous active-low reset
//   req        in  [N]   : raw request lines (asynchronous, level-held)
//   mask       in  [N]   : 1 = line excluded from selection, pending kept
//   out_ready  in        : consumer accepts the presented index
//   clr_ovr    in        : synchronous clear of all overrun flags
//   out_valid  out       : an index is presented
//   out_idx    out [IDX_W]: presented index
//   pending    out [N]   : sticky captured requests
//   overrun    out [N]   : sticky edge-while-pending flags
// -----------------------------------------------------------------------------
module irq_priority_ctrl
   import irq_priority_ctrl_pkg::*;
#(
   parameter int unsigned N     = IRQ_N_DEF,
   parameter int unsigned IDX_W = IRQ_IDX_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     mask,
   input  logic             out_ready,
   input  logic             clr_ovr,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   output logic [N-1:0]     pending,
   output logic [N-1:0]     overrun
);

   irq_state_t       r_state;
   logic [N-1:0]     r_sync1;
   logic [N-1:0]     r_sync2;
   logic [N-1:0]     r_prev;
   logic [N-1:0]     r_pending;
   logic [N-1:0]     r_overrun;
   logic             r_out_valid;
   logic [IDX_W-1:0] r_out_idx;

   logic [N-1:0]     w_edge;
   logic [N-1:0]     w_clr;
   logic [N-1:0]     w_cand;
   logic [3:0]       w_y4;
   logic [1:0]       w_sel;
   logic             w_any;

   assign w_edge = r_sync2 & ~r_prev;
   assign w_cand = r_pending & ~mask;

   // One-hot clear of the presented line on the accept edge.
   assign w_clr = (r_state == ST_PRESENT && out_ready)
                ? ({{(N-1){1'b0}}, 1'b1} << r_out_idx) : '0;

   // Encoder is four lines wide; narrower configurations are zero-padded.
   always_comb begin
      w_y4          = '0;
      w_y4[N-1:0]   = w_cand;
   end

   prio_enc4 u_prio_enc4 (
      .y   (w_y4),
      .a   (w_sel),
      .any (w_any)
   );

   // Synchronizer and previous-value flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
      end else begin
         r_sync1 <= req;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Set dominates clear, so a fresh edge on the accepted line stays pending
   // and, because it is being cleared, does not count as an overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_overrun <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_edge;
         r_overrun <= (clr_ovr ? '0 : r_overrun) | (w_edge & r_pending & ~w_clr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_out_idx   <= IDX_W'(w_sel);
                  r_out_valid <= 1'b1;
                  r_state     <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_idx   = r_out_idx;
   assign pending   = r_pending;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_priority_ctrl
// Directed-vector bench for irq_priority_ctrl. Inputs change on the falling
// edge; outputs are sampled on the falling edge after each rising edge.
// -----------------------------------------------------------------------------
module tb_irq_priority_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] mask;
   logic       out_ready;
   logic       clr_ovr;
   logic       out_valid;
   logic [1:0] out_idx;
   logic [3:0] pending;
   logic [3:0] overrun;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   irq_priority_ctrl #(.N(4), .IDX_W(2)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mask      (mask),
      .out_ready (out_ready),
      .clr_ovr   (clr_ovr),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .pending   (pending),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0; req = '0; mask = '0; out_ready = 1'b0; clr_ovr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_valid",   32'(out_valid), 32'h0);
      check("rst_idx",     32'(out_idx),   32'h0);
      check("rst_pending", 32'(pending),   32'h0);
      check("rst_overrun", 32'(overrun),   32'h0);
      rst_n = 1'b1;
      step(2);

      // Single request on line 2, consumer always ready.
      req = 4'b0100; out_ready = 1'b1;
      step(2);
      check("t1_pend_E2",  32'(pending),   32'h0);
      step(1);
      check("t1_pend_E3",  32'(pending),   32'h4);
      check("t1_valid_E3", 32'(out_valid), 32'h0);
      step(1);
      check("t1_valid_E4", 32'(out_valid), 32'h1);
      check("t1_idx_E4",   32'(out_idx),   32'h2);
      step(1);
      check("t1_valid_acc", 32'(out_valid), 32'h0);
      check("t1_pend_acc",  32'(pending),   32'h0);
      req = '0;
      step(4);

      // Two simultaneous requests: line 3 first, then line 1.
      req = 4'b1010;
      step(3);
      check("t2_pend",   32'(pending),   32'hA);
      step(1);
      check("t2_valid3", 32'(out_valid), 32'h1);
      check("t2_idx3",   32'(out_idx),   32'h3);
      step(1);
      check("t2_gap",    32'(out_valid), 32'h0);
      check("t2_pend1",  32'(pending),   32'h2);
      step(1);
      check("t2_valid1", 32'(out_valid), 32'h1);
      check("t2_idx1",   32'(out_idx),   32'h1);
      step(1);
      check("t2_pend0",  32'(pending),   32'h0);
      req = '0;
      step(4);

      // Masking: line 3 masked, line 0 served, then line 3 after unmask.
      out_ready = 1'b0; mask = 4'b1000; req = 4'b1001;
      step(4);
      check("t3_valid0", 32'(out_valid), 32'h1);
      check("t3_idx0",   32'(out_idx),   32'h0);
      check("t3_pend",   32'(pending),   32'h9);
      out_ready = 1'b1;
      step(1);
      check("t3_pend8",  32'(pending),   32'h8);
      step(1);
      check("t3_masked_idle", 32'(out_valid), 32'h0);
      mask = 4'b0000;
      step(1);
      check("t3_valid3", 32'(out_valid), 32'h1);
      check("t3_idx3",   32'(out_idx),   32'h3);
      step(1);
      check("t3_pend0",  32'(pending),   32'h0);
      req = '0;
      step(4);

      // Overrun on line 1 while presented and not accepted.
      out_ready = 1'b0; req = 4'b0010;
      step(4);
      check("t4_valid", 32'(out_valid), 32'h1);
      req = 4'b0000;
      step(2);
      req = 4'b0010;
      step(4);
      check("t4_overrun",   32'(overrun),   32'h2);
      check("t4_idx_stable", 32'(out_idx),  32'h1);
      check("t4_valid_hold", 32'(out_valid), 32'h1);
      clr_ovr = 1'b1;
      step(1);
      clr_ovr = 1'b0;
      check("t4_ovr_clr",   32'(overrun),   32'h0);
      out_ready = 1'b1;
      step(1);
      check("t4_pend0",     32'(pending),   32'h0);
      req = '0;
      step(4);

      // Fresh edge on line 2 lands on the accept edge of index 2.
      out_ready = 1'b0; req = 4'b0100;
      step(4);
      check("t5_valid", 32'(out_valid), 32'h1);
      check("t5_idx",   32'(out_idx),   32'h2);
      req = 4'b0000;
      step(2);
      req = 4'b0100;
      step(2);
      out_ready = 1'b1;
      step(1);
      check("t5_acc_valid", 32'(out_valid), 32'h0);
      check("t5_pend_kept", 32'(pending),   32'h4);
      check("t5_no_ovr",    32'(overrun),   32'h0);
      step(1);
      check("t5_re_valid",  32'(out_valid), 32'h1);
      check("t5_re_idx",    32'(out_idx),   32'h2);
      step(1);
      check("t5_pend0",     32'(pending),   32'h0);
      req = '0;
      step(4);

      // Asynchronous reset while presenting; held request re-registers once.
      out_ready = 1'b0; req = 4'b0001;
      step(4);
      check("t6_valid_pre", 32'(out_valid), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid",   32'(out_valid), 32'h0);
      check("t6_rst_pending", 32'(pending),   32'h0);
      check("t6_rst_overrun", 32'(overrun),   32'h0);
      check("t6_rst_idx",     32'(out_idx),   32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(2);
      check("t6_no_repres", 32'(out_valid), 32'h0);
      check("t6_pend_E2",   32'(pending),   32'h0);
      step(1);
      check("t6_pend_E3",   32'(pending),   32'h1);
      step(1);
      check("t6_valid_E4",  32'(out_valid), 32'h1);
      check("t6_idx_E4",    32'(out_idx),   32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
